bus_rx_word_flow: RTL
=====================

Name: bus_rx_word_flow

Overview:
Parametrised successor of the single-byte/single-bit bus receiver in the I3C controller datapath. It samples SDA on SCL rising edges and assembles a word of run-time-selectable length (1..MaxBits bits, MSB first). It optionally checks a trailing odd-parity T-bit and supports back-to-back words without losing an SCL edge. It sits between the SCL edge detector and the controller/target flow FSMs.

Parameters:
MaxBits, 9, maximum bits per word including the optional T-bit; legal range 2..16.
CntW, $clog2(MaxBits+1), width of the length and counter fields; derived, not overridden.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
scl_posedge_i  input  1  one-cycle pulse on an SCL rising edge, synchronous to clk_i
sda_i  input  1  synchronised SDA level
rx_req_i  input  1  level request; high keeps the receiver armed, low aborts
rx_len_i  input  CntW  bits per word; sampled at word start
rx_par_chk_i  input  1  1 = the last bit is an odd-parity T-bit; sampled at word start
rx_data_o  output  MaxBits  received data bits, right-aligned, with the T-bit stripped when parity checking is on
rx_done_o  output  1  one-cycle pulse when a word completes
rx_idle_o  output  1  high in Idle
par_err_o  output  1  valid with rx_done_o; 1 = parity mismatch
error_o  output  1  one-cycle pulse when rx_len_i is illegal at start

Behaviour:
- Reset (asynchronous, rst_ni=0) puts the block in these states:
  - state = Idle.
  - rx_data_o = 0, rx_done_o = 0, par_err_o = 0, error_o = 0, rx_idle_o = 1.
  - Shift register and counter = 0.
- Word start: the block is in Idle or Done and rx_req_i=1.
  - Latch rx_len_i into len_q and rx_par_chk_i into par_q.
  - Legal lengths:
    - Without parity: 1 <= len <= MaxBits.
    - With parity: 2 <= len <= MaxBits.
  - Illegal length: pulse error_o for 1 cycle and go to (or stay in) Idle. Re-evaluate start on the next cycle.
- States:
  - Idle: waits for a word start.
    - Legal start: go to Receive, with cnt = len_q and the shift register cleared.
  - Receive: on each clk cycle with scl_posedge_i=1, sample sda_i that same cycle.
    - shift = {shift, sda_i} and cnt = cnt - 1.
    - When cnt reaches 0 after a sample, go to Done.
    - scl_posedge_i pulses outside Receive are ignored, except in the back-to-back case below.
  - Done: lasts exactly 1 cycle.
    - rx_done_o = 1.
    - rx_data_o is registered on entry:
      - Parity on: shift[len-1:1], zero-extended.
      - Parity off: shift[len-1:0], zero-extended.
    - par_err_o = par_q & ~(^shift[len-1:0]), i.e. the XOR of data and T must equal 1.
    - If rx_req_i=1: apply the start rule and go to Receive. A scl_posedge_i in this same cycle is the first bit of the new word, so cnt = len-1.
    - If rx_req_i=0: go to Idle.
- Latency: rx_done_o is asserted on the clk cycle after the last sampled edge.
- rx_data_o and par_err_o hold their value until the next Done. They are not cleared on abort.
- Abort: rx_req_i=0 in Receive forces Idle on the next cycle. No rx_done_o, the partial word is discarded, and no error is flagged.
- len=1 with parity off is a single-bit read, used for ACK/NACK. rx_data_o = {0..., bit}.
- Width rules:
  - The shift register is MaxBits wide.
  - Bits above len are zero because the register is cleared at start.
  - cnt never underflows; the decrement is gated by cnt != 0.

Decomposition:
- Package bus_rx_pkg holds:
  - typedef enum logic [1:0] rx_word_state_e {Idle, Receive, Done}.
  - Localparam T_BIT_ODD = 1'b1.
  - The legal-length check function.
- One natural sub-module: bus_rx_bit_shifter. It holds the shift register plus the down-counter, with inputs clear/load_len/sample/sda and outputs last/shift. The FSM and the parity logic stay in the top level.

Test Plan:
- Byte read: MaxBits=9, len=8, par=0, SDA bits 1,0,1,0,0,1,0,1 on 8 edges -> rx_done_o one cycle after the 8th edge; rx_data_o=0x0A5; par_err_o=0.
- T-bit good/bad: len=9, par=1, data 0x5A then T=1 -> rx_data_o=0x05A, par_err_o=0. Repeat with T=0 -> par_err_o=1.
- Single bit: len=1, par=0, SDA=0 at the edge -> rx_data_o=0x000 and rx_done_o after 1 edge. Repeat with SDA=1 -> 0x001.
- Back-to-back: rx_req_i held high, two len=8 words 0xFF then 0x3C, with an SCL edge in the Done cycle -> two rx_done_o pulses; second rx_data_o=0x03C; no edge lost.
- Abort/illegal length:
  - Drop rx_req_i after 4 edges -> Idle, no done, rx_data_o unchanged.
  - Start with len=0 -> error_o pulse, rx_idle_o=1.
  - Start with len=1 and par=1 -> error_o pulse, rx_idle_o=1.
- Async reset mid-Receive: assert rst_ni=0 between clk edges -> outputs immediately return to their reset values; after release, a new len=8 word receives correctly.

Source files
------------

// File: rtl/bus_rx_pkg.sv
// bus_rx_pkg: shared state type, T-bit polarity and word-length legality check
package bus_rx_pkg;
    typedef enum logic [1:0] {Idle, Receive, Done} rx_word_state_e;
    localparam logic T_BIT_ODD = 1'b1;
    function automatic logic len_ok(input int len, input logic par, input int max_bits);
        return (len >= (par ? 2 : 1)) && (len <= max_bits);
    endfunction
endpackage

// File: rtl/bus_rx_bit_shifter.sv
// bus_rx_bit_shifter: MSB-first shift register with a word-length down-counter
module bus_rx_bit_shifter #(
    parameter int MaxBits = 9,
    localparam int CntW = $clog2(MaxBits + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [CntW-1:0]     len_i,
    input  logic                sample_i,
    input  logic                sda_i,
    output logic                last_o,
    output logic [MaxBits-1:0]  shift_o
);
    logic [MaxBits-1:0] shift_q, shift_d, base_shift;
    logic [CntW-1:0]    cnt_q, cnt_d, base_cnt;
    logic               take;
    // clear/load act first so a sample in the same cycle lands in a fresh word
    always_comb begin
        base_shift = clear_i ? '0 : shift_q;
        base_cnt   = load_i ? len_i : cnt_q;
        take       = sample_i && (base_cnt != '0);
        shift_d    = take ? {base_shift[MaxBits-2:0], sda_i} : base_shift;
        cnt_d      = take ? base_cnt - CntW'(1) : base_cnt;
        last_o     = (base_cnt == CntW'(1));
    end
    assign shift_o = shift_d;
    // shift register and counter state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/bus_rx_word_flow.sv
// bus_rx_word_flow: SCL-edge word receiver with optional odd-parity T-bit
module bus_rx_word_flow
    import bus_rx_pkg::*;
#(
    parameter int MaxBits = 9,
    localparam int CntW = $clog2(MaxBits + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                scl_posedge_i,
    input  logic                sda_i,
    input  logic                rx_req_i,
    input  logic [CntW-1:0]     rx_len_i,
    input  logic                rx_par_chk_i,
    output logic [MaxBits-1:0]  rx_data_o,
    output logic                rx_done_o,
    output logic                rx_idle_o,
    output logic                par_err_o,
    output logic                error_o
);
    rx_word_state_e     state_q, state_d;
    logic [MaxBits-1:0] data_q, data_d, word;
    logic               par_q, par_d, perr_q, perr_d, err_q, err_d;
    logic               clear, load, sample, last, legal, done_d;

    bus_rx_bit_shifter #(.MaxBits(MaxBits)) u_shifter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear),
        .load_i   (load),
        .len_i    (rx_len_i),
        .sample_i (sample),
        .sda_i    (sda_i),
        .last_o   (last),
        .shift_o  (word)
    );

    assign legal = len_ok(int'(rx_len_i), rx_par_chk_i, MaxBits);

    // next state, start/sample control, and result capture on entry to Done
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        load    = 1'b0;
        sample  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            Idle: begin
                if (rx_req_i) begin
                    err_d   = ~legal;
                    load    = legal;
                    clear   = legal;
                    state_d = legal ? Receive : Idle;
                end
            end
            Receive: begin
                if (!rx_req_i) state_d = Idle;
                else if (scl_posedge_i) begin
                    sample  = 1'b1;
                    state_d = last ? Done : Receive;
                end
            end
            Done: begin
                if (!rx_req_i) state_d = Idle;
                else if (legal) begin
                    load    = 1'b1;
                    clear   = 1'b1;
                    sample  = scl_posedge_i;
                    state_d = (scl_posedge_i && last) ? Done : Receive;
                end else begin
                    err_d   = 1'b1;
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase
        par_d  = load ? rx_par_chk_i : par_q;
        done_d = sample && last;
        data_d = done_d ? (par_d ? word >> 1 : word) : data_q;
        perr_d = done_d ? (par_d && ((^word) != T_BIT_ODD)) : perr_q;
    end

    // state and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            data_q  <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            err_q   <= err_d;
        end
    end

    assign rx_data_o = data_q;
    assign rx_done_o = (state_q == Done);
    assign rx_idle_o = (state_q == Idle);
    assign par_err_o = perr_q;
    assign error_o   = err_q;
endmodule
